// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-addressable data memory with sub-word store/load,
// branch resolution and the MEM/WB latch feeding write-back and forwarding.

module mem_access_lane #(
    parameter int LANE    = 0,
    parameter int NB_DATA = 32
) (
    input  logic [1:0]         offset_i,
    input  logic               is_word_i,
    input  logic               is_half_i,
    input  logic               is_byte_i,
    input  logic [NB_DATA-1:0] data_i,
    output logic               we_o,
    output logic [7:0]         wdata_o
);
    localparam logic [1:0] LANE_IDX = LANE[1:0];

    always_comb begin
        we_o = is_word_i
             | (is_half_i & (offset_i[1] == LANE_IDX[1]))
             | (is_byte_i & (offset_i == LANE_IDX));
        // Halfword stores replicate the low halfword into both halves; byte stores into every lane.
        if (is_word_i)
            wdata_o = data_i[8*LANE +: 8];
        else if (is_half_i)
            wdata_o = data_i[8*(LANE%2) +: 8];
        else
            wdata_o = data_i[7:0];
    end
endmodule

module mem_access_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_signed,
    input  logic               i_reg_write,
    input  logic               i_mem_to_reg,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_branch,
    input  logic               i_zero,
    input  logic [NB_PC-1:0]   i_branch_addr,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_REG-1:0]  i_selected_reg,
    input  logic               i_byte_enable,
    input  logic               i_halfword_enable,
    input  logic               i_word_enable,
    input  logic               i_last_register_ctrl,
    input  logic [NB_PC-1:0]   i_pc,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic               o_pc_src,
    output logic [NB_PC-1:0]   o_branch_addr,
    output logic               o_reg_write,
    output logic               o_mem_to_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_REG-1:0]  o_selected_reg,
    output logic               o_last_register_ctrl,
    output logic [NB_PC-1:0]   o_pc,
    output logic               o_halt,
    output logic [NB_DATA-1:0] o_debug_data
);
    localparam int NUM_LANES = NB_DATA / 8;
    localparam int DEPTH     = 1 << NB_ADDR;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic [NB_DATA-1:0] read_data;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_REG-1:0]  selected_reg;
        logic               last_register_ctrl;
        logic [NB_PC-1:0]   pc;
        logic               halt;
    } mem_wb_t;

    logic [NUM_LANES-1:0][7:0] mem_q [DEPTH];

    logic [NB_ADDR-1:0]        widx;
    logic [1:0]                offset;
    logic                      is_word, is_half, is_byte;
    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] lane_wdata;
    logic [NB_DATA-1:0]        rd_word;
    logic [NB_DATA-1:0]        load_data;
    logic [15:0]               rd_half;
    logic [7:0]                rd_byte;
    mem_wb_t                   memwb_q, memwb_d;
    logic                      unused_addr_bits;

    // Upper address bits are intentionally dropped so accesses wrap over the memory.
    assign widx             = i_alu_result[NB_ADDR+1:2];
    assign offset           = i_alu_result[1:0];
    assign unused_addr_bits = ^i_alu_result[NB_DATA-1:NB_ADDR+2];

    assign is_word = i_word_enable;
    assign is_half = ~i_word_enable & i_halfword_enable;
    assign is_byte = ~i_word_enable & ~i_halfword_enable & i_byte_enable;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mem_access_lane #(.LANE(g), .NB_DATA(NB_DATA)) u_lane (
                .offset_i  (offset),
                .is_word_i (is_word),
                .is_half_i (is_half),
                .is_byte_i (is_byte),
                .data_i    (i_data_b),
                .we_o      (lane_we[g]),
                .wdata_o   (lane_wdata[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (!i_reset && i_enable && i_mem_write) begin
            for (int k = 0; k < NUM_LANES; k++)
                if (lane_we[k]) mem_q[widx][k] <= lane_wdata[k];
        end
    end

    // Load path reads pre-store contents, so same-cycle load/store returns old data.
    assign rd_word = mem_q[widx];
    assign rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte = rd_word[8*offset +: 8];

    always_comb begin
        load_data = '0;
        if (i_mem_read) begin
            if (is_word)
                load_data = rd_word;
            else if (is_half)
                load_data = {{16{i_signed & rd_half[15]}}, rd_half};
            else if (is_byte)
                load_data = {{24{i_signed & rd_byte[7]}}, rd_byte};
        end
    end

    always_comb begin
        memwb_d = memwb_q;
        if (i_enable) begin
            memwb_d.reg_write          = i_reg_write;
            memwb_d.mem_to_reg         = i_mem_to_reg;
            memwb_d.read_data          = load_data;
            memwb_d.alu_result         = i_alu_result;
            memwb_d.selected_reg       = i_selected_reg;
            memwb_d.last_register_ctrl = i_last_register_ctrl;
            memwb_d.pc                 = i_pc;
            memwb_d.halt               = i_halt;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) memwb_q <= '0;
        else         memwb_q <= memwb_d;
    end

    assign o_pc_src             = i_branch & i_zero;
    assign o_branch_addr        = i_branch_addr;
    assign o_reg_write          = memwb_q.reg_write;
    assign o_mem_to_reg         = memwb_q.mem_to_reg;
    assign o_read_data          = memwb_q.read_data;
    assign o_alu_result         = memwb_q.alu_result;
    assign o_selected_reg       = memwb_q.selected_reg;
    assign o_last_register_ctrl = memwb_q.last_register_ctrl;
    assign o_pc                 = memwb_q.pc;
    assign o_halt               = memwb_q.halt;
    assign o_debug_data         = mem_q[i_debug_addr];
endmodule
